// File: rtl/logic_reduce_sequencer.sv
// Folds a counted stream of data words into one value through an external
// combinational logic unit (AND / OR / XOR / NOT-A), one word per accepted beat.
module logic_reduce_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startValid,
  output logic                   startReady,
  input  logic [1:0]             opSel,
  input  logic [COUNT_WIDTH-1:0] wordCount,
  input  logic [DATA_WIDTH-1:0]  dataIn,
  input  logic                   dataValid,
  output logic                   dataReady,
  output logic [DATA_WIDTH-1:0]  luA,
  output logic [DATA_WIDTH-1:0]  luB,
  output logic [1:0]             luS,
  input  logic [DATA_WIDTH-1:0]  luResult,
  output logic [DATA_WIDTH-1:0]  resultOut,
  output logic                   resultValid,
  input  logic                   resultReady,
  output logic                   busy,
  output logic                   countError
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } stateE;

  stateE                  stateR;
  stateE                  stateNextS;
  logic [DATA_WIDTH-1:0]  accR;
  logic [COUNT_WIDTH-1:0] remainingR;
  logic [1:0]             opRegR;
  logic                   countErrorR;

  logic startFireS;
  logic dataFireS;
  logic lastWordS;
  logic zeroCountS;

  assign startFireS = (stateR == IDLE) && startValid;
  assign dataFireS  = ((stateR == LOAD) || (stateR == ACCUM)) && dataValid;
  assign lastWordS  = (remainingR == {{(COUNT_WIDTH-1){1'b0}}, 1'b1});
  assign zeroCountS = (wordCount == {COUNT_WIDTH{1'b0}});

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Next-state decode
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      IDLE: begin
        if (startValid) begin
          stateNextS = zeroCountS ? DONE : LOAD;
        end else begin
          stateNextS = IDLE;
        end
      end
      LOAD: begin
        if (dataValid) begin
          stateNextS = lastWordS ? DONE : ACCUM;
        end else begin
          stateNextS = LOAD;
        end
      end
      ACCUM: begin
        if (dataValid && lastWordS) begin
          stateNextS = DONE;
        end else begin
          stateNextS = ACCUM;
        end
      end
      DONE: begin
        if (resultReady) begin
          stateNextS = IDLE;
        end else begin
          stateNextS = DONE;
        end
      end
      default: stateNextS = IDLE;
    endcase
  end

  // Accumulator, word counter, latched op and zero-count flag
  always_ff @(posedge clk) begin
    if (reset) begin
      accR        <= {DATA_WIDTH{1'b0}};
      remainingR  <= {COUNT_WIDTH{1'b0}};
      opRegR      <= 2'b00;
      countErrorR <= 1'b0;
    end else if (startFireS) begin
      opRegR      <= opSel;
      remainingR  <= wordCount;
      countErrorR <= zeroCountS;
      if (zeroCountS) begin
        accR <= {DATA_WIDTH{1'b0}};
      end else begin
        accR <= accR;
      end
    end else if (dataFireS) begin
      // The first word seeds the accumulator; later words go through the logic unit.
      accR <= (stateR == LOAD) ? dataIn : luResult;
      if (remainingR != {COUNT_WIDTH{1'b0}}) begin
        remainingR <= remainingR - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        remainingR <= remainingR;
      end
    end else begin
      accR        <= accR;
      remainingR  <= remainingR;
      opRegR      <= opRegR;
      countErrorR <= countErrorR;
    end
  end

  // Output decode from the registered state
  always_comb begin
    startReady  = 1'b0;
    dataReady   = 1'b0;
    resultValid = 1'b0;
    luB         = {DATA_WIDTH{1'b0}};
    case (stateR)
      IDLE:    startReady = 1'b1;
      LOAD:    dataReady  = 1'b1;
      ACCUM: begin
        dataReady = 1'b1;
        luB       = dataIn;
      end
      DONE:    resultValid = 1'b1;
      default: startReady  = 1'b0;
    endcase
  end

  assign luA        = accR;
  assign luS        = opRegR;
  assign resultOut  = accR;
  assign busy       = (stateR != IDLE);
  assign countError = countErrorR;

endmodule

// File: tb/tb_logic_reduce_sequencer.sv
// Randomized + directed bench for logic_reduce_sequencer with a word-level
// reference model and an in-bench model of the external logic unit.
module tb_logic_reduce_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        startValid;
  logic        startReady;
  logic [1:0]  opSel;
  logic [7:0]  wordCount;
  logic [31:0] dataIn;
  logic        dataValid;
  logic        dataReady;
  logic [31:0] luA;
  logic [31:0] luB;
  logic [1:0]  luS;
  logic [31:0] luResult;
  logic [31:0] resultOut;
  logic        resultValid;
  logic        resultReady;
  logic        busy;
  logic        countError;

  int errors = 0;
  int checks = 0;

  logic_reduce_sequencer #(.DATA_WIDTH(32), .COUNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .startValid(startValid), .startReady(startReady),
    .opSel(opSel), .wordCount(wordCount),
    .dataIn(dataIn), .dataValid(dataValid), .dataReady(dataReady),
    .luA(luA), .luB(luB), .luS(luS), .luResult(luResult),
    .resultOut(resultOut), .resultValid(resultValid), .resultReady(resultReady),
    .busy(busy), .countError(countError)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] applyOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // External logic unit
  assign luResult = applyOp(luS, luA, luB);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference model
  logic        armed = 1'b0;
  logic        mIdle = 1'b1;
  logic        mDone = 1'b0;
  logic        mFirst = 1'b0;
  logic        mErr = 1'b0;
  logic [1:0]  mOp = 2'b00;
  logic [31:0] mAcc = 32'h0;
  int          mLeft = 0;
  logic [31:0] mWords[$];

  always @(negedge clk) begin
    logic [31:0] foldV;
    if (armed) begin
      chk("startReady", startReady, mIdle);
      chk("busy", busy, !mIdle);
      chk("dataReady", dataReady, !mIdle && !mDone);
      chk("resultValid", resultValid, mDone);
      chk("countError", countError, mErr);
      chk("luA", luA, mAcc);
      chk("luS", luS, mOp);
      chk("luB", luB, (!mIdle && !mDone && !mFirst) ? dataIn : 32'h0);
      if (mDone) begin
        foldV = 32'h0;
        for (int i = 0; i < mWords.size(); i++)
          foldV = (i == 0) ? mWords[i] : applyOp(mOp, foldV, mWords[i]);
        chk("resultFold", resultOut, foldV);
      end
    end
    // Predict the effect of the upcoming rising edge
    if (reset) begin
      armed = 1'b1; mIdle = 1'b1; mDone = 1'b0; mFirst = 1'b0;
      mErr = 1'b0; mOp = 2'b00; mAcc = 32'h0; mLeft = 0;
    end else if (mIdle) begin
      if (startValid) begin
        mIdle = 1'b0; mOp = opSel; mLeft = int'(wordCount);
        mWords.delete();
        if (wordCount == 8'd0) begin
          mAcc = 32'h0; mErr = 1'b1; mDone = 1'b1;
        end else begin
          mErr = 1'b0; mFirst = 1'b1;
        end
      end
    end else if (mDone) begin
      if (resultReady) begin
        mDone = 1'b0; mIdle = 1'b1;
      end
    end else if (dataValid) begin
      mWords.push_back(dataIn);
      mAcc = mFirst ? dataIn : applyOp(mOp, mAcc, dataIn);
      mFirst = 1'b0;
      mLeft--;
      if (mLeft == 0) mDone = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startCmd(input logic [1:0] op, input logic [7:0] cnt);
    int n = 0;
    opSel = op; wordCount = cnt; startValid = 1'b1;
    while (!startReady && n < 50) begin tick(); n++; end
    if (!startReady) chk("startTimeout", 32'd0, 32'd1);
    tick();
    startValid = 1'b0; opSel = 2'($urandom); wordCount = 8'($urandom);
  endtask

  task automatic sendWord(input logic [31:0] d, input int gaps);
    int n = 0;
    for (int g = 0; g < gaps; g++) begin
      dataValid = 1'b0; dataIn = $urandom; tick();
    end
    dataIn = d; dataValid = 1'b1;
    while (!dataReady && n < 50) begin tick(); n++; end
    if (!dataReady) chk("dataTimeout", 32'd0, 32'd1);
    tick();
    dataValid = 1'b0; dataIn = $urandom;
  endtask

  task automatic expectResult(input string name, input logic [31:0] exp, input logic err);
    chk({name, "Latency"}, resultValid, 1'b1);
    chk(name, resultOut, exp);
    chk({name, "Err"}, countError, err);
    resultReady = 1'b1; tick(); resultReady = 1'b0;
    chk({name, "Idle"}, busy, 1'b0);
  endtask

  task automatic waitAndRelease(input int hold);
    int n = 0;
    while (!resultValid && n < 400) begin tick(); n++; end
    if (!resultValid) chk("resultTimeout", 32'd0, 32'd1);
    for (int h = 0; h < hold; h++) begin
      startValid = 1'($urandom); opSel = 2'($urandom); wordCount = 8'($urandom);
      tick();
    end
    startValid = 1'b0;
    resultReady = 1'b1; tick(); resultReady = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1; startValid = 1'b0; opSel = 2'b00; wordCount = 8'd0;
    dataIn = 32'h0; dataValid = 1'b0; resultReady = 1'b0;
    tick(); tick();
    chk("rstStartReady", startReady, 1'b1);
    chk("rstBusy", busy, 1'b0);
    chk("rstResultValid", resultValid, 1'b0);
    chk("rstDataReady", dataReady, 1'b0);
    chk("rstLuA", luA, 32'h0);
    chk("rstLuB", luB, 32'h0);
    chk("rstLuS", luS, 2'b00);
    reset = 1'b0;
    tick();

    startCmd(2'b00, 8'd3);
    sendWord(32'hFFFF0000, 0); sendWord(32'hF0F0F0F0, 0); sendWord(32'hFF00FF00, 0);
    expectResult("and3", 32'hF0000000, 1'b0);

    startCmd(2'b10, 8'd2);
    sendWord(32'h12345678, 0); sendWord(32'hFFFFFFFF, 3);
    expectResult("xor2", 32'hEDCBA987, 1'b0);

    startCmd(2'b11, 8'd2);
    sendWord(32'h0000FFFF, 0); sendWord(32'h12345678, 0);
    expectResult("not2", 32'hFFFF0000, 1'b0);
    startCmd(2'b11, 8'd3);
    sendWord(32'h0000FFFF, 0); sendWord(32'h12345678, 1); sendWord(32'hDEADBEEF, 0);
    expectResult("not3", 32'h0000FFFF, 1'b0);

    dataValid = 1'b1; dataIn = 32'h55AA55AA;
    startCmd(2'b01, 8'd0);
    expectResult("zero", 32'h00000000, 1'b1);
    dataValid = 1'b0;

    startCmd(2'b01, 8'd2);
    chk("errClear", countError, 1'b0);
    sendWord(32'h0000FF00, 0); sendWord(32'h000000FF, 0);
    startValid = 1'b1; opSel = 2'b00; wordCount = 8'd1;
    for (int h = 0; h < 5; h++) tick();
    chk("holdValid", resultValid, 1'b1);
    chk("holdOut", resultOut, 32'h0000FFFF);
    startValid = 1'b0;
    expectResult("orHold", 32'h0000FFFF, 1'b0);

    startCmd(2'b00, 8'd4);
    sendWord(32'h89ABCDEF, 0);
    reset = 1'b1; dataValid = 1'b1; dataIn = 32'h0F0F0F0F; resultReady = 1'b1;
    tick();
    reset = 1'b0; dataValid = 1'b0; resultReady = 1'b0;
    chk("midRstBusy", busy, 1'b0);
    chk("midRstStartReady", startReady, 1'b1);
    chk("midRstAcc", luA, 32'h0);
    startCmd(2'b01, 8'd1);
    sendWord(32'hA5A5A5A5, 0);
    expectResult("or1", 32'hA5A5A5A5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if (i == 20) cnt = 255;
      else if ($urandom_range(0, 7) == 0) cnt = 0;
      else cnt = $urandom_range(1, 6);
      startCmd(2'($urandom), 8'(cnt));
      for (int w = 0; w < cnt; w++) sendWord($urandom, $urandom_range(0, 2));
      waitAndRelease($urandom_range(0, 3));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        dataIn = $urandom; dataValid = 1'($urandom); tick();
      end
      dataValid = 1'b0;
    end

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_reduce_sequencer.md
LOGIC_REDUCE_SEQUENCER -- requirements
Module: logic_reduce_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand, accumulator and result width.
REQ-002 SHALL have parameter COUNT_WIDTH, default 8, the width of the word-count field.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 startValid  input  1  a reduction command is presented.
REQ-007 startReady  output  1  the block accepts a command.
REQ-008 opSel  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOT(A); sampled on command accept.
REQ-009 wordCount  input  COUNT_WIDTH  number of data words in the reduction; sampled on command accept.
REQ-010 dataIn  input  DATA_WIDTH  streamed data word.
REQ-011 dataValid  input  1  dataIn is valid.
REQ-012 dataReady  output  1  the block accepts dataIn.
REQ-013 luA  output  DATA_WIDTH  operand A to the external logic unit.
REQ-014 luB  output  DATA_WIDTH  operand B to the external logic unit.
REQ-015 luS  output  2  op select to the external logic unit, same encoding as opSel.
REQ-016 luResult  input  DATA_WIDTH  combinational result from the external logic unit.
REQ-017 resultOut  output  DATA_WIDTH  final reduction value.
REQ-018 resultValid  output  1  resultOut is valid.
REQ-019 resultReady  input  1  the consumer accepts resultOut.
REQ-020 busy  output  1  a command is in progress (state not IDLE).
REQ-021 countError  output  1  the current result came from a zero-count command.

Function
REQ-022 SHALL implement FSM states IDLE, LOAD, ACCUM, DONE.
REQ-023 IDLE: startReady=1; on startValid, latch opSel into opReg and wordCount into remaining. Next state is DONE if wordCount==0, else LOAD.
REQ-024 Zero count: SHALL set acc=0 and countError=1 and enter DONE; resultValid is asserted the cycle after accept.
REQ-025 LOAD: dataReady=1; on dataValid, acc<=dataIn and remaining decrements. Next state is DONE if remaining was 1, else ACCUM.
REQ-026 ACCUM: dataReady=1, luA=acc, luB=dataIn, luS=opReg; on dataValid, acc<=luResult and remaining decrements. Leave for DONE when remaining was 1.
REQ-027 Outside ACCUM, SHALL drive luA=acc, luB=0, luS=opReg.
REQ-028 NOT op: each ACCUM word inverts acc; the data value is ignored but the word is still consumed.
REQ-029 DONE: resultValid=1, resultOut=acc; hold all outputs stable until resultReady=1, then enter IDLE.
REQ-030 Latency: resultValid SHALL rise exactly 1 cycle after the last data word is accepted.
REQ-031 startReady and dataReady SHALL be 0 in any state where they are not specified above.
REQ-032 startValid is ignored outside IDLE; no command is queued.
REQ-033 wordCount of all ones SHALL be supported (remaining never wraps, because the decrement only occurs when remaining≥1).
REQ-034 countError SHALL clear on the next command accept with nonzero wordCount.
REQ-035 Data stalls (dataValid=0) SHALL leave acc and remaining unchanged indefinitely.

Reset
REQ-036 On reset=1 at a clock edge, from any state including mid-reduction: state=IDLE, acc=0, remaining=0, opReg=00, countError=0.
REQ-037 After that edge the outputs SHALL be: resultValid=0, dataReady=0, busy=0, startReady=1, luA=0, luB=0, luS=00.
REQ-038 Reset SHALL take priority over all handshakes in the same cycle.

Verification
REQ-039 AND, count 3, words FFFF0000, F0F0F0F0, FF00FF00 -> resultOut=F0000000, resultValid 1 cycle after the third word.
REQ-040 XOR, count 2, words 12345678, FFFFFFFF, with 3 idle cycles between words -> resultOut=EDCBA987.
REQ-041 NOT, count 2, words 0000FFFF, 12345678 -> resultOut=FFFF0000; with count 3 and a third word -> 0000FFFF.
REQ-042 Command with count 0 -> resultValid next cycle, resultOut=00000000, countError=1, no data consumed.
REQ-043 OR, count 2, result 0000FFFF with resultReady held low 5 cycles -> output stable for 5 cycles, IDLE one cycle after resultReady=1; a second start during DONE is ignored.
REQ-044 Reset asserted after word 1 of a count-4 AND -> next cycle busy=0, startReady=1, acc=0; a new OR count-1 of word A5A5A5A5 -> A5A5A5A5.
